aes_spi_frame_if: RTL and testbench
===================================

// Module: aes_spi_frame_if
// PURPOSE
//  SPI-slave framing front end for the AES core, generalised over key size and direction mode.
//  Synchronises sck/sdi/load into clk, shifts in {dir byte, block, key} MSB-first, and runs a start/ready handshake with the core.
//  Shifts the 128-bit result out on sdo while done is high. Adds frame-length/dir-byte error detection and back-to-back frames.
// PARAMETERS
//  K            128  key bits; legal 128, 192, 256
//  INV          2    0 = encrypt only, 1 = decrypt only, 2 = per-frame dir byte (8'h00 enc, 8'hFF dec)
//  SYNC_STAGES  2    flops per sck/sdi/load synchroniser (>=2)
//  FRAME        K+128+(INV==2?8:0), derived localparam, never overridden
// PORTS
//  clk                input   1    system clock
//  reset_n            input   1    asynchronous active-low reset
//  sck                input   1    SPI clock, async to clk; high and low phases each >= SYNC_STAGES+2 clk
//  sdi                input   1    serial data in, sampled on synchronised sck rise
//  load               input   1    high = frame in progress; falling edge ends frame
//  sdo                output  1    serial result out, MSB first
//  done               output  1    result ready for shift-out
//  frame_err          output  1    last frame rejected (sticky until next load rise)
//  core_start         output  1    request to core, held until core_ready
//  core_ready         input   1    core accepts request when core_start && core_ready
//  core_dir           output  1    0 = encrypt, 1 = decrypt
//  core_key           output  K    key field of the frame
//  core_block         output  128  plaintext/ciphertext field of the frame
//  core_result        input   128  core output
//  core_result_valid  input   1    one-cycle pulse, core_result valid
// BEHAVIOUR
//  Reset: state IDLE; sdo=0, done=0, frame_err=0, core_start=0, core_dir=0, core_key=0, core_block=0; bit counter=0; sync chains=0.
//  Edges: rise/fall detected on the last two synchroniser stages; one event per clk at most.
//  States: IDLE, SHIFT_IN, CHECK, REQ, WAIT, SHIFT_OUT.
//  IDLE: load rise -> SHIFT_IN; clear counter, frame_err, done.
//  SHIFT_IN: each sck rise shifts sdi into FRAME-bit register LSB; counter saturates at FRAME+1.
//   load fall -> CHECK.
//  CHECK (1 cycle): counter != FRAME, or INV==2 with dir byte not 00/FF -> frame_err=1, IDLE.
//   Else latch fields: dir byte = bits [FRAME-1:FRAME-8], block next 128 bits, key low K bits.
//   core_dir = INV==2 ? dir[0] : INV; -> REQ.
//  REQ: core_start=1 until core_start&&core_ready; key/block/dir stable throughout; -> WAIT.
//  WAIT: core_result_valid -> load 128-bit out register; sdo = result[127]; done=1; out counter=0; -> SHIFT_OUT.
//  SHIFT_OUT: sdo stable across sck rise (master samples after rise).
//   Each sck fall shifts next bit out; out counter increments.
//   After 128th fall: done=0, sdo=0, -> IDLE.
//  Latency: core_start asserts SYNC_STAGES+2 clk after load fall at pins; done asserts 1 clk after core_result_valid.
//  load rise in any state other than IDLE/SHIFT_IN aborts current frame:
//   done=0, core_start=0, -> SHIFT_IN with counter cleared.
//   A core_result_valid arriving after abort is ignored.
//  sck edges while load low and not SHIFT_OUT are ignored; sdi ignored while load low.
//  core_result_valid outside WAIT is ignored.
//  reset_n low mid-frame: immediate return to reset values; partial frame discarded.
// TESTING
//  K=128, INV=2: dir 00, key 2B7E151628AED2A6ABF7158809CF4F3C, block 3243F6A8885A308D313198A2E0370734; core model returns 3925841D02DC09FBDC118597196A0B32 -> core_dir=0, fields match, 128 sdo bits equal 3925841D...0B32.
//  K=128, INV=2, dir FF, block 3925841D02DC09FBDC118597196A0B32 -> core_dir=1; key/block fields match frame.
//  K=256, INV=0: key 000102...1F, block 00112233445566778899AABBCCDDEEFF -> FRAME=384; core sees exact fields; result 8EA2B7CA516745BFEAFC49904B496089 shifted out.
//  Short frame (263 bits, INV=2, K=128) -> frame_err=1, core_start never asserts; next good frame -> frame_err clears, completes normally.
//  INV=2, dir byte 8'h5A -> frame_err=1; core_ready held low 20 clk in REQ -> core_start stays high, fields stable.
//  load rise during SHIFT_OUT after 40 bits -> done=0, new frame accepted; reset_n pulse in WAIT -> all outputs return to reset values.

Source files
------------

// File: rtl/aes_spi_frame_if.sv
// SPI-slave framing front end for the AES core: shifts in {dir, block, key} MSB-first, hands the fields to the core, then shifts the 128-bit result out on sdo.
// core_start rises SYNC_STAGES+2 clk after load falls and is held until core_ready; done rises 1 clk after core_result_valid.
module aes_spi_frame_if #(
    parameter int K           = 128,
    parameter int INV         = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           sck,
    input  logic           sdi,
    input  logic           load,
    output logic           sdo,
    output logic           done,
    output logic           frame_err,
    output logic           core_start,
    input  logic           core_ready,
    output logic           core_dir,
    output logic [K-1:0]   core_key,
    output logic [127:0]   core_block,
    input  logic [127:0]   core_result,
    input  logic           core_result_valid
);
    localparam int DW    = (INV == 2) ? 8 : 0;
    localparam int FRAME = K + 128 + DW;
    localparam int CW    = $clog2(FRAME + 2);
    localparam logic [CW-1:0] CNT_FRAME = CW'(FRAME);
    localparam logic [CW-1:0] CNT_SAT   = CW'(FRAME + 1);

    typedef enum logic [2:0] {IDLE, SHIFT_IN, CHECK, REQ, WAIT, SHIFT_OUT} state_t;

    state_t                 state, state_nxt;
    logic [SYNC_STAGES-1:0] sck_sync, sdi_sync, load_sync;
    logic                   sck_rise, sck_fall, load_rise, load_fall, sdi_bit;
    logic [FRAME-1:0]       shreg;
    logic [CW-1:0]          bit_cnt;
    logic [127:0]           out_reg;
    logic [6:0]             out_cnt;
    logic [7:0]             dir_byte;
    logic                   frame_ok;

    // Edge events are registered so each one lasts exactly one clk; sdi is
    // captured from the same stage as sck so the bit lines up with its rise.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sck_sync  <= '0;
            sdi_sync  <= '0;
            load_sync <= '0;
            sck_rise  <= 1'b0;
            sck_fall  <= 1'b0;
            load_rise <= 1'b0;
            load_fall <= 1'b0;
            sdi_bit   <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
            sdi_sync  <= {sdi_sync[SYNC_STAGES-2:0], sdi};
            load_sync <= {load_sync[SYNC_STAGES-2:0], load};
            sck_rise  <=  sck_sync[SYNC_STAGES-2]  & ~sck_sync[SYNC_STAGES-1];
            sck_fall  <= ~sck_sync[SYNC_STAGES-2]  &  sck_sync[SYNC_STAGES-1];
            load_rise <=  load_sync[SYNC_STAGES-2] & ~load_sync[SYNC_STAGES-1];
            load_fall <= ~load_sync[SYNC_STAGES-2] &  load_sync[SYNC_STAGES-1];
            sdi_bit   <= sdi_sync[SYNC_STAGES-2];
        end
    end

    assign dir_byte = shreg[FRAME-1 -: 8];
    assign frame_ok = (bit_cnt == CNT_FRAME) &&
                      ((INV != 2) || (dir_byte == 8'h00) || (dir_byte == 8'hFF));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (load_rise) state_nxt = SHIFT_IN;
            SHIFT_IN:  if (load_fall) state_nxt = CHECK;
            CHECK:     state_nxt = frame_ok ? REQ : IDLE;
            REQ:       if (core_ready) state_nxt = WAIT;
            WAIT:      if (core_result_valid) state_nxt = SHIFT_OUT;
            SHIFT_OUT: if (sck_fall && out_cnt == 7'd127) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
        // A new frame start pre-empts whatever is in flight.
        if (load_rise && state != SHIFT_IN) state_nxt = SHIFT_IN;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shreg      <= '0;
            bit_cnt    <= '0;
            out_reg    <= '0;
            out_cnt    <= '0;
            sdo        <= 1'b0;
            done       <= 1'b0;
            frame_err  <= 1'b0;
            core_start <= 1'b0;
            core_dir   <= 1'b0;
            core_key   <= '0;
            core_block <= '0;
        end else if (load_rise && state != SHIFT_IN) begin
            bit_cnt    <= '0;
            frame_err  <= 1'b0;
            done       <= 1'b0;
            sdo        <= 1'b0;
            core_start <= 1'b0;
        end else begin
            case (state)
                SHIFT_IN: if (sck_rise) begin
                    shreg <= {shreg[FRAME-2:0], sdi_bit};
                    if (bit_cnt != CNT_SAT) bit_cnt <= bit_cnt + CW'(1);
                end
                CHECK: if (!frame_ok) begin
                    frame_err <= 1'b1;
                end else begin
                    core_dir   <= (INV == 2) ? dir_byte[0] : (INV == 1);
                    core_block <= shreg[K +: 128];
                    core_key   <= shreg[K-1:0];
                    core_start <= 1'b1;
                end
                REQ: if (core_ready) core_start <= 1'b0;
                WAIT: if (core_result_valid) begin
                    out_reg <= core_result;
                    sdo     <= core_result[127];
                    done    <= 1'b1;
                    out_cnt <= '0;
                end
                // sdo only moves on sck fall so it is stable across the master's sampling rise.
                SHIFT_OUT: if (sck_fall) begin
                    if (out_cnt == 7'd127) begin
                        done <= 1'b0;
                        sdo  <= 1'b0;
                    end else begin
                        out_reg <= {out_reg[126:0], 1'b0};
                        sdo     <= out_reg[126];
                    end
                    out_cnt <= out_cnt + 7'd1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_spi_frame_if.sv
// Bench: K=128/INV=2 and K=256/INV=0 instances share the SPI pins; a table plus random frames drive a frame-level model.
module tb_aes_spi_frame_if;
    localparam int HP = 4;

    typedef struct {
        logic [7:0]   dir;
        logic [127:0] key;
        logic [127:0] block;
        logic [127:0] result;
        int           len;
        int           hold;
        logic         exp_err;
        logic         exp_dir;
    } vec_t;

    logic         clk = 1'b0;
    logic         reset_n, sck, sdi, load, core_ready, core_result_valid;
    logic [127:0] core_result;
    logic         sdo_a, done_a, err_a, start_a, dir_a;
    logic [127:0] key_a, block_a;
    logic         sdo_b, done_b, err_b, start_b, dir_b;
    logic [255:0] key_b;
    logic [127:0] block_b;
    int           checks = 0;
    int           errors = 0;
    vec_t         tbl [7];

    always #5 clk = ~clk;

    aes_spi_frame_if #(.K(128), .INV(2), .SYNC_STAGES(2)) dut_a (
        .clk(clk), .reset_n(reset_n), .sck(sck), .sdi(sdi), .load(load),
        .sdo(sdo_a), .done(done_a), .frame_err(err_a), .core_start(start_a),
        .core_ready(core_ready), .core_dir(dir_a), .core_key(key_a), .core_block(block_a),
        .core_result(core_result), .core_result_valid(core_result_valid));

    aes_spi_frame_if #(.K(256), .INV(0), .SYNC_STAGES(2)) dut_b (
        .clk(clk), .reset_n(reset_n), .sck(sck), .sdi(sdi), .load(load),
        .sdo(sdo_b), .done(done_b), .frame_err(err_b), .core_start(start_b),
        .core_ready(core_ready), .core_dir(dir_b), .core_key(key_b), .core_block(block_b),
        .core_result(core_result), .core_result_valid(core_result_valid));

    function automatic logic cur_start(input bit b); return b ? start_b : start_a; endfunction
    function automatic logic cur_done(input bit b);  return b ? done_b  : done_a;  endfunction
    function automatic logic cur_sdo(input bit b);   return b ? sdo_b   : sdo_a;   endfunction

    // Frame-level rule for the K=128 dir-byte variant.
    function automatic logic model_err(input logic [7:0] dir, input int len);
        return (len != 264) || !((dir == 8'h00) || (dir == 8'hFF));
    endfunction

    task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", name, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [399:0] bits, input int len);
        load = 1'b1;
        tick(HP);
        for (int i = len - 1; i >= 0; i--) begin
            sdi = bits[i];
            tick(HP);
            sck = 1'b1;
            tick(HP);
            sck = 1'b0;
        end
        tick(HP);
        sdi  = 1'b0;
        load = 1'b0;
    endtask

    task automatic wait_start(input bit b, output int n);
        n = 0;
        while ((cur_start(b) !== 1'b1) && (n < 40)) begin
            tick(1);
            n++;
        end
    endtask

    task automatic core_run(input bit b, input logic [255:0] ekey, input logic [127:0] eblk,
                            input logic edir, input logic [127:0] res, input int hold, input bit give);
        bit stable;
        chk("core_dir", b ? dir_b : dir_a, edir);
        chk("core_key", b ? key_b : {128'b0, key_a}, ekey);
        chk("core_block", b ? block_b : block_a, eblk);
        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            tick(1);
            if (cur_start(b) !== 1'b1 || (b ? key_b : {128'b0, key_a}) !== ekey ||
                (b ? block_b : block_a) !== eblk || (b ? dir_b : dir_a) !== edir) stable = 1'b0;
        end
        if (hold > 0) chk("req_hold_stable", stable, 1'b1);
        core_ready = 1'b1;
        tick(1);
        core_ready = 1'b0;
        chk("start_drop", cur_start(b), 1'b0);
        if (give) begin
            tick(3);
            chk("done_pre", cur_done(b), 1'b0);
            core_result       = res;
            core_result_valid = 1'b1;
            tick(1);
            core_result_valid = 1'b0;
            chk("done_rise", cur_done(b), 1'b1);
            chk("sdo_first", cur_sdo(b), res[127]);
        end
    endtask

    task automatic shift_out(input bit b, input int nbits, output logic [127:0] got);
        got = '0;
        for (int i = 0; i < nbits; i++) begin
            sck = 1'b1;
            tick(HP);
            got[127-i] = cur_sdo(b);
            sck = 1'b0;
            tick(HP);
        end
    endtask

    task automatic run_vec(input vec_t v);
        logic [399:0] frame;
        logic [127:0] got;
        int           n;
        bit           seen;
        frame = '0;
        frame[263:0] = {v.dir, v.block, v.key};
        send_frame(frame, v.len);
        if (v.exp_err) begin
            seen = 1'b0;
            for (int i = 0; i < 12; i++) begin
                tick(1);
                if (start_a) seen = 1'b1;
            end
            chk("frame_err", err_a, 1'b1);
            chk("no_start", seen, 1'b0);
        end else begin
            wait_start(1'b0, n);
            chk("start_latency", n, 4);
            chk("err_clear", err_a, 1'b0);
            core_run(1'b0, {128'b0, v.key}, v.block, v.exp_dir, v.result, v.hold, 1'b1);
            shift_out(1'b0, 128, got);
            chk("sdo_stream", got, v.result);
            tick(2);
            chk("done_fall", done_a, 1'b0);
            chk("sdo_idle", sdo_a, 1'b0);
        end
    endtask

    task automatic start_and_accept(input vec_t v);
        logic [399:0] frame;
        int           n;
        frame = '0;
        frame[263:0] = {v.dir, v.block, v.key};
        send_frame(frame, 264);
        wait_start(1'b0, n);
        chk("start_seen", n < 40, 1'b1);
        core_run(1'b0, {128'b0, v.key}, v.block, v.exp_dir, v.result, 0, 1'b0);
    endtask

    initial begin
        vec_t         v;
        logic [399:0] frame;
        logic [127:0] got;
        logic [255:0] key256;
        logic [127:0] blk256, res256;
        int           n;

        reset_n = 1'b0; sck = 1'b0; sdi = 1'b0; load = 1'b0;
        core_ready = 1'b0; core_result_valid = 1'b0; core_result = '0;
        tick(3);
        chk("rst_sdo", sdo_a, 1'b0);
        chk("rst_done", done_a, 1'b0);
        chk("rst_err", err_a, 1'b0);
        chk("rst_start", start_a, 1'b0);
        chk("rst_fields_a", {dir_a, key_a, block_a}, '0);
        chk("rst_fields_b", {sdo_b, done_b, err_b, start_b, dir_b, key_b[127:0], block_b}, '0);
        reset_n = 1'b1;
        tick(2);

        tbl[0] = '{8'h00, 128'h2B7E151628AED2A6ABF7158809CF4F3C, 128'h3243F6A8885A308D313198A2E0370734,
                   128'h3925841D02DC09FBDC118597196A0B32, 264, 0, 1'b0, 1'b0};
        tbl[1] = '{8'hFF, 128'h2B7E151628AED2A6ABF7158809CF4F3C, 128'h3925841D02DC09FBDC118597196A0B32,
                   128'h3243F6A8885A308D313198A2E0370734, 264, 0, 1'b0, 1'b1};
        tbl[2] = '{8'h00, 128'h2B7E151628AED2A6ABF7158809CF4F3C, 128'h3243F6A8885A308D313198A2E0370734,
                   128'h0, 263, 0, 1'b1, 1'b0};
        tbl[3] = tbl[0];
        tbl[4] = '{8'h5A, 128'h000102030405060708090A0B0C0D0E0F, 128'h00112233445566778899AABBCCDDEEFF,
                   128'h0, 264, 0, 1'b1, 1'b0};
        tbl[5] = '{8'hFF, 128'h000102030405060708090A0B0C0D0E0F, 128'h00112233445566778899AABBCCDDEEFF,
                   128'h69C4E0D86A7B0430D8CDB78070B4C55A, 264, 20, 1'b0, 1'b1};
        tbl[6] = '{8'h00, 128'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF, 128'h0, 128'h0, 265, 0, 1'b1, 1'b0};
        for (int i = 0; i < 7; i++) run_vec(tbl[i]);

        for (int r = 0; r < 5; r++) begin
            case ($urandom_range(0, 2))
                0:       v.dir = 8'h00;
                1:       v.dir = 8'hFF;
                default: v.dir = 8'($urandom_range(1, 254));
            endcase
            v.key     = {$urandom, $urandom, $urandom, $urandom};
            v.block   = {$urandom, $urandom, $urandom, $urandom};
            v.result  = {$urandom, $urandom, $urandom, $urandom};
            v.len     = ($urandom_range(0, 3) == 0) ? 263 : 264;
            v.hold    = $urandom_range(0, 5);
            v.exp_err = model_err(v.dir, v.len);
            v.exp_dir = (v.dir == 8'hFF);
            run_vec(v);
        end

        // K=256, fixed encrypt direction: 384-bit frame with no dir byte.
        key256 = 256'h000102030405060708090A0B0C0D0E0F101112131415161718191A1B1C1D1E1F;
        blk256 = 128'h00112233445566778899AABBCCDDEEFF;
        res256 = 128'h8EA2B7CA516745BFEAFC49904B496089;
        frame = '0;
        frame[383:0] = {blk256, key256};
        send_frame(frame, 384);
        wait_start(1'b1, n);
        chk("k256_latency", n, 4);
        chk("k256_long_err_a", err_a, 1'b1);
        core_run(1'b1, key256, blk256, 1'b0, res256, 0, 1'b1);
        shift_out(1'b1, 128, got);
        chk("k256_sdo_stream", got, res256);
        tick(2);
        chk("k256_done_fall", done_b, 1'b0);

        // New frame during shift-out, 40 bits in.
        start_and_accept(tbl[0]);
        core_result = tbl[0].result;
        core_result_valid = 1'b1;
        tick(1);
        core_result_valid = 1'b0;
        shift_out(1'b0, 40, got);
        chk("abort_bits", got[127:88], tbl[0].result[127:88]);
        load = 1'b1;
        tick(6);
        chk("abort_done", done_a, 1'b0);
        run_vec(tbl[1]);

        // New frame while waiting for the core; the late result must be dropped.
        start_and_accept(tbl[1]);
        load = 1'b1;
        tick(6);
        core_result = tbl[1].result;
        core_result_valid = 1'b1;
        tick(1);
        core_result_valid = 1'b0;
        tick(2);
        chk("late_result_done", done_a, 1'b0);
        chk("late_result_start", start_a, 1'b0);
        run_vec(tbl[0]);

        // Reset while waiting for the core.
        start_and_accept(tbl[5]);
        reset_n = 1'b0;
        #1;
        chk("rst_wait_a", {sdo_a, done_a, err_a, start_a, dir_a, key_a, block_a}, '0);
        chk("rst_wait_b", {done_b, start_b, key_b[127:0], block_b}, '0);
        tick(2);
        reset_n = 1'b1;
        tick(2);
        core_result = tbl[5].result;
        core_result_valid = 1'b1;
        tick(1);
        core_result_valid = 1'b0;
        tick(1);
        chk("rst_wait_done", done_a, 1'b0);
        run_vec(tbl[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL timeout got running exp finished");
        $fatal(1, "timeout");
    end
endmodule
